// File: rtl/tdl_pkg.sv
// -----------------------------------------------------------------------------
// tdl_pkg
// Shared types and helpers for the tagged delay line.
//   tdl_state_e : config state machine encoding (IDLE / DRAIN)
//   popcount    : number of set bits in a (zero-extended) 32-bit vector
// The per-stage struct {valid, data} depends on DATA_WIDTH, so it is declared
// inside tdl_lane where that parameter is known.
// -----------------------------------------------------------------------------
package tdl_pkg;

    typedef enum logic [0:0] {
        TDL_IDLE  = 1'b0,
        TDL_DRAIN = 1'b1
    } tdl_state_e;

    localparam int unsigned POP_W = 32;

    // Callers zero-extend their lane vectors to POP_W bits.
    function automatic logic [5:0] popcount(input logic [POP_W-1:0] vec);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < POP_W; i++) begin
            cnt = cnt + {5'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/tdl_lane.sv
// -----------------------------------------------------------------------------
// tdl_lane
// One channel of the delay line: MAX_DELAY {valid,data} stages plus the
// combinational tap at stage (cur_delay-1).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   advance         shift all stages one position
//   flush           clear every stage (priority over advance)
//   in_valid        accepted valid for stage 0 (already gated by the top)
//   in_data         lane data presented at stage 0
//   cur_delay       active delay, 1..MAX_DELAY
//   out_valid/data  contents of the tap stage
// -----------------------------------------------------------------------------
module tdl_lane
    import tdl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned MAX_DELAY  = 4,
    parameter int unsigned DW         = $clog2(MAX_DELAY + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DW-1:0]         cur_delay,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q [MAX_DELAY];
    stage_t stage_d [MAX_DELAY];
    stage_t shift_s [MAX_DELAY];
    stage_t in_stage_s;
    stage_t tap_s;

    // Build the stage-0 entry; a lane that is not accepted carries zero data.
    always_comb begin
        in_stage_s = '0;
        if (in_valid) begin
            in_stage_s.valid = 1'b1;
            in_stage_s.data  = in_data;
        end else begin
            in_stage_s = '0;
        end
    end

    // Shifted view of the stage array (what every stage would take on advance).
    always_comb begin
        shift_s[0] = in_stage_s;
        for (int i = 1; i < MAX_DELAY; i++) begin
            shift_s[i] = stage_q[i-1];
        end
    end

    // Next stage state. Stages at or beyond cur_delay are written empty so that
    // nothing stale is waiting there when the delay is later increased.
    always_comb begin
        for (int i = 0; i < MAX_DELAY; i++) begin
            stage_d[i] = flush   ? stage_t'('0) :
                         advance ? ((DW'(i) < cur_delay) ? shift_s[i] : stage_t'('0)) :
                                   stage_q[i];
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Tap mux: select stage (cur_delay-1).
    always_comb begin
        tap_s = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            tap_s = (DW'(i) == (cur_delay - DW'(1))) ? stage_q[i] : tap_s;
        end
    end

    assign out_valid = tap_s.valid;
    assign out_data  = tap_s.data;

endmodule

// File: rtl/tagged_delay_line.sv
// -----------------------------------------------------------------------------
// tagged_delay_line
// Multi-lane valid-tagged delay line with a run-time programmable delay
// (1..MAX_DELAY). A delay change waits (DRAIN) until no valid entry is in
// flight; flush discards everything in flight.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   advance               shift enable for all lanes
//   flush                 drop all in-flight entries (priority over advance)
//   in_valid, in_data     per-lane entry presented at stage 0
//   cfg_load, cfg_delay   request to change the delay
//   cfg_busy              drain in progress, inputs ignored
//   cfg_err               one-cycle pulse for a rejected cfg_load
//   cur_delay             active delay
//   pending               valid entries currently in active stages, all lanes
//   out_valid, out_data   tap stage (cur_delay-1) per lane, combinational
// -----------------------------------------------------------------------------
module tagged_delay_line
    import tdl_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 10,
    parameter  int unsigned CHANNELS      = 2,
    parameter  int unsigned MAX_DELAY     = 4,
    parameter  int unsigned DEFAULT_DELAY = 1,
    localparam int unsigned DW            = $clog2(MAX_DELAY + 1),
    localparam int unsigned PW            = $clog2(CHANNELS * MAX_DELAY + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         advance,
    input  logic                         flush,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic                         cfg_load,
    input  logic [DW-1:0]                cfg_delay,
    output logic                         cfg_busy,
    output logic                         cfg_err,
    output logic [DW-1:0]                cur_delay,
    output logic [PW-1:0]                pending,
    output logic [CHANNELS-1:0]          out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data
);

    tdl_state_e           state_q, state_d;
    logic [DW-1:0]        cur_delay_q, cur_delay_d;
    logic [DW-1:0]        target_q, target_d;
    logic [PW-1:0]        pending_q, pending_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 busy_s;
    logic                 cfg_ok_s;
    logic [CHANNELS-1:0]  acc_valid_s;

    assign busy_s      = (state_q == TDL_DRAIN);
    assign acc_valid_s = in_valid & ~{CHANNELS{busy_s}};
    assign cfg_ok_s    = (cfg_delay != '0) && (cfg_delay <= DW'(MAX_DELAY));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        tdl_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_DELAY  (MAX_DELAY),
            .DW         (DW)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .advance   (advance),
            .flush     (flush),
            .in_valid  (acc_valid_s[c]),
            .in_data   (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .cur_delay (cur_delay_q),
            .out_valid (out_valid[c]),
            .out_data  (out_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // In-flight count: entries enter at stage 0 and leave when the tap is
    // consumed by an advance.
    always_comb begin
        pending_d = pending_q;
        if (flush) begin
            pending_d = '0;
        end else if (advance) begin
            pending_d = pending_q
                      + PW'(popcount(POP_W'(acc_valid_s)))
                      - PW'(popcount(POP_W'(out_valid)));
        end else begin
            pending_d = pending_q;
        end
    end

    // Config state machine: next state, delay update and error pulse.
    always_comb begin
        state_d     = state_q;
        cur_delay_d = cur_delay_q;
        target_d    = target_q;
        cfg_err_d   = 1'b0;
        case (state_q)
            TDL_IDLE: begin
                if (cfg_load) begin
                    if (!cfg_ok_s) begin
                        cfg_err_d = 1'b1;
                    end else if ((pending_q == '0) || flush) begin
                        cur_delay_d = cfg_delay;
                    end else begin
                        target_d = cfg_delay;
                        state_d  = TDL_DRAIN;
                    end
                end else begin
                    state_d = TDL_IDLE;
                end
            end
            TDL_DRAIN: begin
                cfg_err_d = cfg_load;
                // Registered pending is used so the switch happens only after
                // the last entry has actually left the active stages.
                if ((pending_q == '0) || flush) begin
                    cur_delay_d = target_q;
                    state_d     = TDL_IDLE;
                end else begin
                    state_d = TDL_DRAIN;
                end
            end
            default: begin
                state_d = TDL_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= TDL_IDLE;
            cur_delay_q <= DW'(DEFAULT_DELAY);
            target_q    <= DW'(DEFAULT_DELAY);
            pending_q   <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_delay_q <= cur_delay_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign cfg_busy  = busy_s;
    assign cfg_err   = cfg_err_q;
    assign cur_delay = cur_delay_q;
    assign pending   = pending_q;

endmodule
